// File: rtl/dram_access_ctrl.sv
// dram_access_ctrl: sequences CPU byte/bit requests into single-cycle RAM
// accesses, including read-modify-write for bit set/clear/complement.
// All RAM-side outputs are registered so the RAM sees clean strobes.
// Build option: define DRAM_SFR_BIT_EN to allow bit addresses 0x80-0xFF;
// without it those bit addresses are rejected with err.
module dram_access_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic [2:0] op,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic       wbit,
   output logic       ack,
   output logic       err,
   output logic       busy,
   output logic [7:0] rdata,
   output logic       rbit,
   output logic       CS,
   output logic       RW,
   output logic       Bb,
   output logic [7:0] ram_addr,
   output logic [7:0] position,
   output logic [7:0] din,
   output logic       bin,
   input  logic [7:0] dout,
   input  logic       bout
);

   localparam logic [2:0] OP_BYTE_RD = 3'b000;
   localparam logic [2:0] OP_BYTE_WR = 3'b001;
   localparam logic [2:0] OP_BIT_RD  = 3'b010;
   localparam logic [2:0] OP_BIT_WR  = 3'b011;
   localparam logic [2:0] OP_BIT_SET = 3'b100;
   localparam logic [2:0] OP_BIT_CLR = 3'b101;
   localparam logic [2:0] OP_ILLEGAL = 3'b111;

   typedef enum logic [2:0] {IDLE, ACC, CAPT, WR, DONE} state_t;

   state_t     state;
   state_t     next_state;
   logic [2:0] op_q;
   logic       ill_q;

   logic       in_bit_op;
   logic       in_write;
   logic       sfr_blocked;
   logic       in_illegal;
   logic [7:0] map_addr;
   logic [7:0] map_pos;

   // Decode the incoming request: operation class, legality and RAM address mapping.
   always_comb begin
      in_bit_op = (op != OP_BYTE_RD) && (op != OP_BYTE_WR) && (op != OP_ILLEGAL);
      in_write  = (op == OP_BYTE_WR) || (op == OP_BIT_WR);
`ifdef DRAM_SFR_BIT_EN
      sfr_blocked = 1'b0;
`else
      sfr_blocked = in_bit_op && addr[7];
`endif
      in_illegal = (op == OP_ILLEGAL) || sfr_blocked;
      map_addr   = addr;
      map_pos    = 8'h00;
      if (in_bit_op) begin
         if (addr[7]) begin
            map_addr = {addr[7:3], 3'b000};
         end else begin
            map_addr = 8'h20 + {4'h0, addr[6:3]};
         end
         map_pos = 8'h01 << addr[2:0];
      end
   end

   // Next-state logic: writes finish after the access, reads capture, RMW adds a write-back.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req) begin
               next_state = in_illegal ? DONE : ACC;
            end
         end
         ACC: begin
            if ((op_q == OP_BYTE_WR) || (op_q == OP_BIT_WR)) begin
               next_state = DONE;
            end else begin
               next_state = CAPT;
            end
         end
         CAPT: begin
            if ((op_q == OP_BYTE_RD) || (op_q == OP_BIT_RD)) begin
               next_state = DONE;
            end else begin
               next_state = WR;
            end
         end
         WR:      next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Registered RAM strobes, latched request and captured read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         CS       <= 1'b1;
         RW       <= 1'b1;
         Bb       <= 1'b1;
         ram_addr <= 8'h00;
         position <= 8'h00;
         din      <= 8'h00;
         bin      <= 1'b0;
         rdata    <= 8'h00;
         rbit     <= 1'b0;
         op_q     <= OP_BYTE_RD;
         ill_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  op_q  <= op;
                  ill_q <= in_illegal;
                  if (!in_illegal) begin
                     CS       <= 1'b0;
                     RW       <= !in_write;
                     Bb       <= !in_bit_op;
                     ram_addr <= map_addr;
                     position <= map_pos;
                     if (op == OP_BYTE_WR) begin
                        din <= wdata;
                     end
                     if (op == OP_BIT_WR) begin
                        bin <= wbit;
                     end
                  end
               end
            end
            ACC: begin
               CS <= 1'b1;
               RW <= 1'b1;
            end
            CAPT: begin
               rdata <= dout;
               rbit  <= bout;
               if (next_state == WR) begin
                  CS <= 1'b0;
                  RW <= 1'b0;
                  if (op_q == OP_BIT_SET) begin
                     bin <= 1'b1;
                  end else if (op_q == OP_BIT_CLR) begin
                     bin <= 1'b0;
                  end else begin
                     bin <= ~bout;
                  end
               end
            end
            WR: begin
               CS <= 1'b1;
               RW <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign ack  = (state == DONE);
   assign err  = (state == DONE) && ill_q;

endmodule

// File: tb/tb_dram_access_ctrl.sv
// tb_dram_access_ctrl: directed transactions against a behavioural RAM;
// expected acks are queued at issue time and checked by an ack monitor.
module tb_dram_access_ctrl;

   localparam logic [2:0] BYTE_RD = 3'b000;
   localparam logic [2:0] BYTE_WR = 3'b001;
   localparam logic [2:0] BIT_RD  = 3'b010;
   localparam logic [2:0] BIT_WR  = 3'b011;
   localparam logic [2:0] BIT_SET = 3'b100;
   localparam logic [2:0] BIT_CLR = 3'b101;
   localparam logic [2:0] BIT_CPL = 3'b110;
   localparam logic [2:0] ILLEGAL = 3'b111;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0;
   logic [2:0] op = 3'b000;
   logic [7:0] addr = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic       wbit = 1'b0;
   logic       ack, err, busy, rbit, CS, RW, Bb, bin;
   logic [7:0] rdata, ram_addr, position, din;
   logic [7:0] dout;
   logic       bout;

   typedef struct {
      string      tag;
      logic       err;
      int         lat;
      bit         chkD;
      logic [7:0] d;
      bit         chkB;
      logic       b;
      int         issue;
   } exp_t;

   exp_t sb[$];
   exp_t monEntry;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int rdCnt = 0;
   int wrCnt = 0;
   int ackCount = 0;
   int rdBase = 0;
   int wrBase = 0;
   int ackBase = 0;
   logic [7:0] mem [0:255];
   logic [7:0] lastRdAddr, lastRdPos, lastWrAddr, lastWrPos, lastWrDin;
   logic       lastWrBin, lastWrBb;

   dram_access_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr),
      .wdata(wdata), .wbit(wbit), .ack(ack), .err(err), .busy(busy),
      .rdata(rdata), .rbit(rbit), .CS(CS), .RW(RW), .Bb(Bb),
      .ram_addr(ram_addr), .position(position), .din(din), .bin(bin),
      .dout(dout), .bout(bout)
   );

   always #5 clk = ~clk;

   // Cycle counter used for ack latency measurement.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Behavioural RAM: commits writes and returns read data one cycle after a read strobe.
   always @(posedge clk) begin
      if (!CS) begin
         if (RW) begin
            dout       <= mem[ram_addr];
            bout       <= |(mem[ram_addr] & position);
            rdCnt      <= rdCnt + 1;
            lastRdAddr <= ram_addr;
            lastRdPos  <= position;
         end else begin
            if (Bb) begin
               mem[ram_addr] <= din;
            end else if (bin) begin
               mem[ram_addr] <= mem[ram_addr] | position;
            end else begin
               mem[ram_addr] <= mem[ram_addr] & ~position;
            end
            wrCnt      <= wrCnt + 1;
            lastWrAddr <= ram_addr;
            lastWrPos  <= position;
            lastWrDin  <= din;
            lastWrBin  <= bin;
            lastWrBb   <= Bb;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Ack monitor: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && ack) begin
         ackCount <= ackCount + 1;
         if (sb.size() == 0) begin
            checkOutput("unexpected_ack", {31'b0, ack}, 32'd0);
         end else begin
            monEntry = sb.pop_front();
            checkOutput($sformatf("%s_err", monEntry.tag), {31'b0, err}, {31'b0, monEntry.err});
            if (monEntry.lat != 0) begin
               checkOutput($sformatf("%s_latency", monEntry.tag), cyc - monEntry.issue + 1, monEntry.lat);
            end
            if (monEntry.chkD) begin
               checkOutput($sformatf("%s_rdata", monEntry.tag), {24'b0, rdata}, {24'b0, monEntry.d});
            end
            if (monEntry.chkB) begin
               checkOutput($sformatf("%s_rbit", monEntry.tag), {31'b0, rbit}, {31'b0, monEntry.b});
            end
         end
      end
   end

   task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [7:0] a,
                                input logic [7:0] wd, input logic wb, input logic eErr,
                                input int eLat, input bit cD, input logic [7:0] eD,
                                input bit cB, input logic eB);
      exp_t e;
      @(negedge clk);
      req    = 1'b1;
      op     = o;
      addr   = a;
      wdata  = wd;
      wbit   = wb;
      rdBase = rdCnt;
      wrBase = wrCnt;
      @(posedge clk);
      #1;
      e.tag   = tag;
      e.err   = eErr;
      e.lat   = eLat;
      e.chkD  = cD;
      e.d     = eD;
      e.chkB  = cB;
      e.b     = eB;
      e.issue = cyc;
      sb.push_back(e);
      req = 1'b0;
      checkOutput($sformatf("%s_busy", tag), {31'b0, busy}, 32'd1);
   endtask

   task automatic waitDone(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         checkOutput($sformatf("%s_timeout", tag), sb.size(), 32'd0);
         sb.delete();
      end
      repeat (2) @(negedge clk);
      checkOutput($sformatf("%s_idle", tag), {31'b0, busy}, 32'd0);
   endtask

   task automatic checkAccesses(input string tag, input int expRd, input int expWr);
      checkOutput($sformatf("%s_reads", tag), rdCnt - rdBase, expRd);
      checkOutput($sformatf("%s_writes", tag), wrCnt - wrBase, expWr);
   endtask

   // Directed sequence.
   initial begin
      bit found;
      #12;
      checkOutput("rst_CS", {31'b0, CS}, 32'd1);
      checkOutput("rst_RW", {31'b0, RW}, 32'd1);
      checkOutput("rst_Bb", {31'b0, Bb}, 32'd1);
      checkOutput("rst_ram_addr", {24'b0, ram_addr}, 32'h00);
      checkOutput("rst_position", {24'b0, position}, 32'h00);
      checkOutput("rst_din_bin", {23'b0, din, bin}, 32'h000);
      checkOutput("rst_ack_err_busy", {29'b0, ack, err, busy}, 32'd0);
      checkOutput("rst_rdata_rbit", {23'b0, rdata, rbit}, 32'h000);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("pre21", BYTE_WR, 8'h21, 8'h00, 1'b0, 1'b0, 2, 0, 8'h00, 0, 1'b0);
      waitDone("pre21");
      applyStimulus("pre22", BYTE_WR, 8'h22, 8'h00, 1'b0, 1'b0, 2, 0, 8'h00, 0, 1'b0);
      waitDone("pre22");
      applyStimulus("preE0", BYTE_WR, 8'hE0, 8'h08, 1'b0, 1'b0, 2, 0, 8'h00, 0, 1'b0);
      waitDone("preE0");

      applyStimulus("wr07", BYTE_WR, 8'h07, 8'h78, 1'b0, 1'b0, 2, 0, 8'h00, 0, 1'b0);
      waitDone("wr07");
      checkAccesses("wr07", 0, 1);
      checkOutput("wr07_addr", {24'b0, lastWrAddr}, 32'h07);
      checkOutput("wr07_din", {24'b0, lastWrDin}, 32'h78);
      checkOutput("wr07_Bb", {31'b0, lastWrBb}, 32'd1);
      checkOutput("wr07_mem", {24'b0, mem[8'h07]}, 32'h78);

      applyStimulus("rd07", BYTE_RD, 8'h07, 8'h00, 1'b0, 1'b0, 3, 1, 8'h78, 0, 1'b0);
      waitDone("rd07");
      checkAccesses("rd07", 1, 0);
      checkOutput("rd07_addr", {24'b0, lastRdAddr}, 32'h07);

      applyStimulus("set0B", BIT_SET, 8'h0B, 8'h00, 1'b0, 1'b0, 4, 0, 8'h00, 1, 1'b0);
      waitDone("set0B");
      checkAccesses("set0B", 1, 1);
      checkOutput("set0B_rdaddr", {24'b0, lastRdAddr}, 32'h21);
      checkOutput("set0B_rdpos", {24'b0, lastRdPos}, 32'h08);
      checkOutput("set0B_wraddr", {24'b0, lastWrAddr}, 32'h21);
      checkOutput("set0B_wrpos", {24'b0, lastWrPos}, 32'h08);
      checkOutput("set0B_bin", {31'b0, lastWrBin}, 32'd1);
      checkOutput("set0B_Bb", {31'b0, lastWrBb}, 32'd0);
      checkOutput("set0B_mem", {24'b0, mem[8'h21]}, 32'h08);

      applyStimulus("clr0B", BIT_CLR, 8'h0B, 8'h00, 1'b0, 1'b0, 4, 0, 8'h00, 1, 1'b1);
      waitDone("clr0B");
      checkOutput("clr0B_mem", {24'b0, mem[8'h21]}, 32'h00);

      applyStimulus("cpl0B_a", BIT_CPL, 8'h0B, 8'h00, 1'b0, 1'b0, 4, 0, 8'h00, 1, 1'b0);
      waitDone("cpl0B_a");
      checkOutput("cpl0B_a_mem", {24'b0, mem[8'h21]}, 32'h08);
      applyStimulus("cpl0B_b", BIT_CPL, 8'h0B, 8'h00, 1'b0, 1'b0, 4, 0, 8'h00, 1, 1'b1);
      waitDone("cpl0B_b");
      checkOutput("cpl0B_b_mem", {24'b0, mem[8'h21]}, 32'h00);
      checkOutput("cpl0B_b_bin", {31'b0, lastWrBin}, 32'd0);
      applyStimulus("rd0B", BIT_RD, 8'h0B, 8'h00, 1'b0, 1'b0, 3, 0, 8'h00, 1, 1'b0);
      waitDone("rd0B");
      checkAccesses("rd0B", 1, 0);

      applyStimulus("wr13", BIT_WR, 8'h13, 8'h00, 1'b1, 1'b0, 2, 0, 8'h00, 0, 1'b0);
      waitDone("wr13");
      checkAccesses("wr13", 0, 1);
      checkOutput("wr13_addr", {24'b0, lastWrAddr}, 32'h22);
      checkOutput("wr13_pos", {24'b0, lastWrPos}, 32'h08);
      checkOutput("wr13_mem", {24'b0, mem[8'h22]}, 32'h08);
      applyStimulus("rd13", BIT_RD, 8'h13, 8'h00, 1'b0, 1'b0, 3, 0, 8'h00, 1, 1'b1);
      waitDone("rd13");

`ifdef DRAM_SFR_BIT_EN
      applyStimulus("rdE3", BIT_RD, 8'hE3, 8'h00, 1'b0, 1'b0, 3, 0, 8'h00, 1, 1'b1);
      waitDone("rdE3");
      checkAccesses("rdE3", 1, 0);
      checkOutput("rdE3_addr", {24'b0, lastRdAddr}, 32'hE0);
      checkOutput("rdE3_pos", {24'b0, lastRdPos}, 32'h08);
`else
      applyStimulus("rdE3", BIT_RD, 8'hE3, 8'h00, 1'b0, 1'b1, 0, 0, 8'h00, 0, 1'b0);
      waitDone("rdE3");
      checkAccesses("rdE3", 0, 0);
`endif

      applyStimulus("ill", ILLEGAL, 8'h07, 8'h55, 1'b1, 1'b1, 0, 0, 8'h00, 0, 1'b0);
      waitDone("ill");
      checkAccesses("ill", 0, 0);

      applyStimulus("set0B_2", BIT_SET, 8'h0B, 8'h00, 1'b0, 1'b0, 4, 0, 8'h00, 1, 1'b0);
      waitDone("set0B_2");
      applyStimulus("abort", BIT_CLR, 8'h0B, 8'h00, 1'b0, 1'b0, 4, 0, 8'h00, 0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!CS && !RW) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("abort_wr_seen", {31'b0, found}, 32'd1);
      rst_n = 1'b0;
      #1;
      sb.delete();
      ackBase = ackCount;
      checkOutput("abort_CS", {31'b0, CS}, 32'd1);
      checkOutput("abort_RW", {31'b0, RW}, 32'd1);
      checkOutput("abort_busy_ack", {30'b0, busy, ack}, 32'd0);
      checkOutput("abort_rdata", {24'b0, rdata}, 32'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("abort_writes", wrCnt - wrBase, 32'd0);
      checkOutput("abort_mem", {24'b0, mem[8'h21]}, 32'h08);
      checkOutput("abort_no_ack", ackCount - ackBase, 32'd0);

      applyStimulus("ill_2", ILLEGAL, 8'h00, 8'h00, 1'b0, 1'b1, 0, 0, 8'h00, 0, 1'b0);
      waitDone("ill_2");
      checkAccesses("ill_2", 0, 0);
      applyStimulus("rd07_2", BYTE_RD, 8'h07, 8'h00, 1'b0, 1'b0, 3, 1, 8'h78, 0, 1'b0);
      waitDone("rd07_2");

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
